// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// status bit layout and serializer states.
package mmio_uart_tx_pkg;

  localparam logic [15:0] OFF_DATA = 16'd0;
  localparam logic [15:0] OFF_STAT = 16'd1;
  localparam logic [15:0] OFF_DIV  = 16'd2;

  localparam int STAT_OVF      = 15;
  localparam int STAT_BUSY     = 8;
  localparam int STAT_FREE_LSB = 3;
  localparam int STAT_EMPTY    = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // A zero divisor would make a bit last forever; treat it as one cycle.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an occupancy counter.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores fill a TX FIFO, an 8N1
// serializer drains it, and loads return status and the baud divisor.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hC004,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wrt_data,
  output logic [15:0] rd_data,
  output logic        TX,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit_data, hit_stat, hit_div;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic [4:0]    free_count;
  logic [15:0]   status;
  logic [15:0]   div;
  logic          ovf;
  logic          busy;

  tx_state_t     state, state_n;
  logic [7:0]    shifter, shifter_n;
  logic [15:0]   bit_len, bit_len_n;
  logic [15:0]   cyc_cnt, cyc_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          tx_q, tx_n;
  logic          bit_done;

  assign hit_data  = (addr == BASE_ADDR + OFF_DATA);
  assign hit_stat  = (addr == BASE_ADDR + OFF_STAT);
  assign hit_div   = (addr == BASE_ADDR + OFF_DIV);
  assign fifo_push = we && hit_data;
  assign drop      = fifo_push && fifo_full && !fifo_pop;
  assign free_count = 5'(FIFO_DEPTH) - 5'(fifo_count);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (wrt_data[7:0]),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    status                           = '0;
    status[STAT_OVF]                 = ovf;
    status[STAT_BUSY]                = busy;
    status[STAT_FREE_LSB +: 5]       = free_count;
    status[STAT_EMPTY]               = fifo_empty;
  end

  // Reads capture pre-write state; an overflow set beats a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      ovf     <= 1'b0;
      div     <= DIV_RESET;
      busy    <= 1'b0;
    end else begin
      if (re && hit_stat)     rd_data <= status;
      else if (re && hit_div) rd_data <= div;
      else                    rd_data <= '0;
      if (we && hit_div) div <= wrt_data;
      if (drop)                 ovf <= 1'b1;
      else if (re && hit_stat)  ovf <= 1'b0;
      busy <= !fifo_empty || (state != ST_IDLE);
    end
  end

  assign bit_done = (cyc_cnt == bit_len - 16'd1);

  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    bit_len_n = bit_len;
    cyc_n     = cyc_cnt + 16'd1;
    bit_idx_n = bit_idx;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        cyc_n = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shifter_n = fifo_dout;
          bit_len_n = eff_div(div);
          state_n   = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cyc_n     = '0;
          bit_idx_n = '0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cyc_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
          end else begin
            shifter_n = shifter >> 1;
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cyc_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Line level follows the state being entered so TX stays registered.
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shifter_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shifter <= '0;
      bit_len <= 16'd1;
      cyc_cnt <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      shifter <= shifter_n;
      bit_len <= bit_len_n;
      cyc_cnt <= cyc_n;
      bit_idx <= bit_idx_n;
      tx_q    <= tx_n;
    end
  end

  assign TX      = tx_q;
  assign tx_busy = busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected reads and serial bytes are
// queued by the stimulus and consumed by independent monitors.
module tb_mmio_uart_tx;

  localparam logic [15:0] A_DATA = 16'hC004;
  localparam logic [15:0] A_STAT = 16'hC005;
  localparam logic [15:0] A_DIV  = 16'hC006;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wrt_data = '0;
  logic [15:0] rd_data;
  logic        tx;
  logic        tx_busy;

  mmio_uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wrt_data (wrt_data),
    .rd_data  (rd_data),
    .TX       (tx),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] val;
  } rd_exp_t;

  int        tests = 0;
  int        fails = 0;
  int        cyc = 0;
  int        bl = 434;
  logic      mon_en = 1'b0;
  logic      re_d = 1'b0;
  rd_exp_t   rd_q[$];
  logic [7:0] tx_exp_q[$];
  int        frame_start[$];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    re_d <= re;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
    addr = a; re = r; we = w; wrt_data = d;
    @(posedge clk);
    #1;
    addr = '0; re = 1'b0; we = 1'b0; wrt_data = '0;
  endtask

  task automatic doRead(input logic [15:0] a, input string name, input logic [15:0] exp);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    rd_q.push_back(e);
    applyStimulus(a, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(a, 1'b0, 1'b1, d);
  endtask

  task automatic waitBusyLow(input string name, input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) seen = 1'b1;
    end
    if (!seen) timeoutFail(name);
  endtask

  // Read monitor: a read issued on one edge is due on the following cycle.
  initial begin : rd_mon
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (re_d) begin
          if (rd_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL rd_unexpected: got %h expected no read", rd_data);
          end else begin
            e = rd_q.pop_front();
            checkOutput(e.name, rd_data, e.val);
          end
        end else begin
          checkOutput("rd_idle_zero", rd_data, 16'h0000);
        end
      end
    end
  end

  // Serial monitor: samples every cycle of a frame using the expected bit length.
  initial begin : tx_mon
    logic [9:0] lvl;
    int         bad;
    logic       aborted;
    int         len;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        frame_start.push_back(cyc);
        lvl = '0; bad = 0; aborted = 1'b0; len = bl;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < len; c++) begin
            if (!aborted) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst)              aborted = 1'b1;
              else if (c == 0)      lvl[b] = tx;
              else if (tx !== lvl[b]) bad++;
            end
          end
        end
        if (!aborted) begin
          if (tx_exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL tx_unexpected_frame: got %h expected no frame", lvl[8:1]);
          end else begin
            e = tx_exp_q.pop_front();
            checkOutput("tx_byte", {8'h00, lvl[8:1]}, {8'h00, e});
            checkOutput("tx_start_stop", {14'h0, lvl[9], lvl[0]}, 16'h0002);
            checkOutput("tx_bit_hold", 16'(bad), 16'h0000);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int w;
    int n;
    int lows;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    checkOutput("reset_tx", {15'h0, tx}, 16'h0001);
    checkOutput("reset_busy", {15'h0, tx_busy}, 16'h0000);
    checkOutput("reset_rd_data", rd_data, 16'h0000);

    // Register map after reset, plus ignored accesses.
    doRead(A_STAT, "stat_reset", 16'h0041);
    doRead(A_DIV, "div_reset", 16'd434);
    doRead(A_DATA, "data_reads_zero", 16'h0000);
    doRead(16'hC007, "unmapped_read_zero", 16'h0000);
    doWrite(A_STAT, 16'hFFFF);
    doWrite(16'hC003, 16'h00AA);
    doRead(A_STAT, "stat_after_ignored_writes", 16'h0041);

    // Single frame 0xA5 at 4 cycles per bit.
    doWrite(A_DIV, 16'd4);
    bl = 4;
    doRead(A_DIV, "div_written", 16'd4);
    n = frame_start.size();
    tx_exp_q.push_back(8'hA5);
    doWrite(A_DATA, 16'h00A5);
    w = cyc;
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_rises", {15'h0, tx_busy}, 16'h0001);
    waitBusyLow("busy_drop_a5", 200);
    checkOutput("busy_drop_cycle", 16'(cyc - w), 16'd42);
    if (frame_start.size() > n) checkOutput("frame_start_a5", 16'(frame_start[n] - w), 16'd1);
    else timeoutFail("frame_start_a5");

    // Nine accepted bytes, a tenth dropped, sticky overflow cleared by read.
    n = frame_start.size();
    for (int i = 0; i < 9; i++) begin
      tx_exp_q.push_back(8'(8'h10 + i));
      doWrite(A_DATA, 16'(16'h0010 + i));
    end
    doWrite(A_DATA, 16'h00EE);
    doRead(A_STAT, "stat_overflow", 16'h8100);
    doRead(A_STAT, "stat_ovf_cleared", 16'h0100);
    waitBusyLow("busy_drop_burst", 9 * 45 + 20);
    checkOutput("burst_frames", 16'(frame_start.size() - n), 16'd9);
    checkOutput("burst_all_sent", 16'(tx_exp_q.size()), 16'd0);

    // Divisor 0 behaves as 1; back-to-back frames are 11 cycles apart.
    doWrite(A_DIV, 16'd0);
    bl = 1;
    doRead(A_DIV, "div_zero", 16'd0);
    n = frame_start.size();
    tx_exp_q.push_back(8'h3C);
    tx_exp_q.push_back(8'hC3);
    doWrite(A_DATA, 16'h003C);
    w = cyc;
    doWrite(A_DATA, 16'h00C3);
    waitBusyLow("busy_drop_div0", 100);
    if (frame_start.size() == n + 2) begin
      checkOutput("div0_first_start", 16'(frame_start[n] - w), 16'd1);
      checkOutput("div0_b2b_gap", 16'(frame_start[n+1] - frame_start[n]), 16'd11);
    end else begin
      timeoutFail("div0_frames");
    end

    // Reset during the data bits of the second of three queued bytes.
    doWrite(A_DIV, 16'd4);
    bl = 4;
    n = frame_start.size();
    tx_exp_q.push_back(8'h5A);
    doWrite(A_DATA, 16'h005A);
    doWrite(A_DATA, 16'h0096);
    doWrite(A_DATA, 16'h0069);
    for (int i = 0; i < 120 && frame_start.size() < n + 2; i++) @(negedge clk);
    if (frame_start.size() < n + 2) timeoutFail("second_frame_start");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("tx_after_rst", {15'h0, tx}, 16'h0001);
    rst = 1'b0;
    bl = 434;
    checkOutput("busy_after_rst", {15'h0, tx_busy}, 16'h0000);
    doRead(A_STAT, "stat_after_rst", 16'h0041);
    doRead(A_DIV, "div_after_rst", 16'd434);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checkOutput("tx_idle_after_rst", 16'(lows), 16'd0);
    checkOutput("no_frames_after_rst", 16'(frame_start.size() - n), 16'd2);

    // Simultaneous read and write of the divisor returns the old value.
    rd_q.push_back('{name: "rmw_old", val: 16'd434});
    applyStimulus(A_DIV, 1'b1, 1'b1, 16'd10);
    doRead(A_DIV, "rmw_new", 16'd10);

    repeat (3) @(negedge clk);
    checkOutput("rd_queue_drained", 16'(rd_q.size()), 16'd0);
    checkOutput("tx_queue_drained", 16'(tx_exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
